prog_loader: RTL and testbench

Writer side of the CPU program memory. It receives a framed byte stream and assembles 16-bit instruction words from it. It writes those words sequentially into a writable program store that presents the same addr/dout read view the fetch path already uses. It holds the CPU in reset until a checksum-verified image is fully written.

---
 rtl/prog_loader.sv | 127 ++++++++++++
 tb/tb_prog_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program-store loader: hunts for a framed byte stream, packs byte pairs into
// instruction words, writes them sequentially and releases the CPU once the image checksum matches.
module prog_loader #(
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_LEN, S_HI, S_LO, S_CHK, S_DONE, S_ERR
  } state_t;

  // A LEN byte of zero encodes a full-depth image.
  localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t          state;
  logic [7:0]      checksum;
  logic [7:0]      hi;
  logic [ADDR_W:0] length;
  logic            accept;

  assign accept = rx_valid && rx_ready;

  // NOTE: every register here, outputs included, is updated with <= in one
  // clocked block so all of them see the same pre-edge values of each other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: reset clears only control/status state; the program store itself
      // lives outside this block and is never bulk-cleared.
      state    <= S_IDLE;
      rx_ready <= 1'b0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      word_cnt <= '0;
      checksum <= '0;
      length   <= '0;
      hi       <= '0;
    end else begin
      we <= 1'b0;
      // After each write the address steps on, so a full-depth load leaves it at 0.
      if (we) waddr <= waddr + ADDR_W'(1);

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_SYNC;
            rx_ready <= 1'b1;
            word_cnt <= '0;
            checksum <= '0;
            waddr    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
          end
        end

        S_SYNC: begin
          if (accept && rx_data == SYNC_BYTE) state <= S_LEN;
        end

        S_LEN: begin
          if (accept) begin
            length <= (rx_data == 8'h00) ? FULL_LEN : (ADDR_W+1)'(rx_data);
            state  <= S_HI;
          end
        end

        S_HI: begin
          if (accept) begin
            hi       <= rx_data;
            checksum <= checksum ^ rx_data;
            state    <= S_LO;
          end
        end

        S_LO: begin
          if (accept) begin
            checksum <= checksum ^ rx_data;
            we       <= 1'b1;
            waddr    <= word_cnt[ADDR_W-1:0];
            wdata    <= DATA_W'({hi, rx_data});
            word_cnt <= word_cnt + (ADDR_W+1)'(1);
            state    <= (word_cnt + (ADDR_W+1)'(1) == length) ? S_CHK : S_HI;
          end
        end

        S_CHK: begin
          if (accept) begin
            rx_ready <= 1'b0;
            if (rx_data == checksum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end

        default: begin
          state    <= S_IDLE;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: expected writes are queued as frames are
// sent and compared against the write port as each we pulse appears.
module tb_prog_loader;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_cnt;

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  wr_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    wr_t e;
    if (rst !== 1'b1 && we === 1'b1) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {23'd0, waddr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("waddr", waddr, e.addr);
        check("wdata", wdata, e.data);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte has transferred.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rx_ready) check("rx_ready_timeout", rx_ready, 1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] words[$], input logic [7:0] len_byte,
                            input bit bad_chk, input bit gaps);
    logic [7:0] chk;
    chk = 8'h00;
    send_byte(8'hA5);
    if (gaps) idle_cycle();
    send_byte(len_byte);
    if (gaps) idle_cycle();
    for (int i = 0; i < words.size(); i++) begin
      chk = chk ^ words[i][15:8] ^ words[i][7:0];
      send_byte(words[i][15:8]);
      if (gaps) idle_cycle();
      exp_q.push_back(wr_t'{addr: ADDR_W'(i), data: words[i]});
      send_byte(words[i][7:0]);
      if (gaps) idle_cycle();
    end
    send_byte(bad_chk ? (chk ^ 8'h01) : chk);
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(done || err) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_finished"}, done | err, 1);
  endtask

  logic [15:0] words[$];

  initial begin
    rst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #2 rst = 1'b1;
    #10;
    check("rst_rx_ready", rx_ready, 0);
    check("rst_we", we, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_word_cnt", word_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycle();
    check("idle_rx_ready", rx_ready, 0);

    // Basic load, back to back
    wr_seen = 0;
    pulse_start();
    check("start_rx_ready", rx_ready, 1);
    words = '{16'h1234, 16'hC001};
    send_frame(words, 8'd2, 1'b0, 1'b0);
    wait_end("basic");
    check("basic_done", done, 1);
    check("basic_err", err, 0);
    check("basic_cpu_hold", cpu_hold, 0);
    check("basic_word_cnt", word_cnt, 2);
    check("basic_writes", wr_seen, 2);
    check("basic_rx_ready", rx_ready, 0);

    // Reload from DONE into a bad-checksum frame
    wr_seen = 0;
    pulse_start();
    check("reload_done_fall", done, 0);
    check("reload_cpu_hold", cpu_hold, 1);
    check("reload_word_cnt", word_cnt, 0);
    send_frame(words, 8'd2, 1'b1, 1'b0);
    wait_end("badchk");
    check("badchk_err", err, 1);
    check("badchk_done", done, 0);
    check("badchk_cpu_hold", cpu_hold, 1);
    check("badchk_writes", wr_seen, 2);

    // Sync hunt with rx_valid toggling every other cycle
    wr_seen = 0;
    pulse_start();
    check("hunt_err_clear", err, 0);
    send_byte(8'h00); idle_cycle();
    send_byte(8'hFF); idle_cycle();
    words = '{16'hABCD};
    send_frame(words, 8'd1, 1'b0, 1'b1);
    wait_end("hunt");
    check("hunt_done", done, 1);
    check("hunt_writes", wr_seen, 1);
    check("hunt_word_cnt", word_cnt, 1);

    // Full-depth wrap
    wr_seen = 0;
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back({8'(i), ~8'(i)});
    pulse_start();
    send_frame(words, 8'd0, 1'b0, 1'b0);
    wait_end("wrap");
    check("wrap_done", done, 1);
    check("wrap_word_cnt", word_cnt, 256);
    check("wrap_waddr", waddr, 0);
    check("wrap_writes", wr_seen, 256);

    // Reset after the HI byte of word 3
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'd5);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'(8'h10 + i));
      exp_q.push_back(wr_t'{addr: ADDR_W'(i), data: {8'(8'h10 + i), 8'(8'h20 + i)}});
      send_byte(8'(8'h20 + i));
    end
    send_byte(8'h33);
    rst = 1'b1;
    #2;
    check("midrst_rx_ready", rx_ready, 0);
    check("midrst_we", we, 0);
    check("midrst_cpu_hold", cpu_hold, 1);
    check("midrst_word_cnt", word_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_queue_drained", exp_q.size(), 0);
    wr_seen = 0;
    words = '{16'h0102, 16'h0304, 16'hF00D};
    pulse_start();
    send_frame(words, 8'd3, 1'b0, 1'b0);
    wait_end("postrst");
    check("postrst_done", done, 1);
    check("postrst_word_cnt", word_cnt, 3);
    check("postrst_writes", wr_seen, 3);

    // Reload after DONE: hold asserted until the new image is verified
    pulse_start();
    check("reload2_done_fall", done, 0);
    check("reload2_cpu_hold", cpu_hold, 1);
    words = '{16'hBEEF};
    send_frame(words, 8'd1, 1'b0, 1'b0);
    wait_end("reload2");
    check("reload2_done", done, 1);
    check("reload2_cpu_hold_rel", cpu_hold, 0);

    idle_cycle();
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
